// File: rtl/mode7_pkg.sv
// Shared constants, state encodings and record types for the Mode 7 scan controller.
// Optional build macro used by this slice: ANGLE_AUTO_ROTATE_EN.
package mode7_pkg;

  localparam int COORD_W = 16;
  localparam int ANGLE_W = 10;
  localparam int COLOR_W = 8;

  localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(359);

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int PIPE_LAT_DEF = 2;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  typedef struct packed {
    logic [COORD_W-1:0] origin_x;
    logic [COORD_W-1:0] origin_y;
    logic [COORD_W-1:0] offset_x;
    logic [COORD_W-1:0] offset_y;
    logic [ANGLE_W-1:0] angle;
  } cfg_t;

  typedef struct packed {
    logic               valid;
    logic [COLOR_W-1:0] color;
    logic               sof;
    logic               eol;
  } pix_t;

  // Next angle index for auto-rotation, wrapping back to 0 after ANGLE_MAX.
  function automatic logic [ANGLE_W-1:0] angle_next(input logic [ANGLE_W-1:0] a);
    return (a >= ANGLE_MAX) ? '0 : a + ANGLE_W'(1);
  endfunction

endpackage

// File: rtl/mode7_scan_ctrl_if.sv
// Valid/ready pixel stream from the scan controller to the video output FIFO.
interface mode7_scan_ctrl_if;
  import mode7_pkg::*;

  logic               pix_valid;
  logic               pix_ready;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_sof;
  logic               pix_eol;

  modport master (output pix_valid, pix_color, pix_sof, pix_eol, input pix_ready);
  modport slave  (input pix_valid, pix_color, pix_sof, pix_eol, output pix_ready);

endinterface

// File: rtl/mode7_pix_pipe.sv
// PIPE_LAT-deep shift pipeline of {valid,color,sof,eol}; the whole pipe moves only on adv.
module mode7_pix_pipe
  import mode7_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  input  pix_t in_pix,
  output pix_t out_pix,
  output logic upstream_empty
);

  pix_t stage [PIPE_LAT];

  // NOTE: the colour payload is reset along with the valids because the spec
  // requires every output, pix_color included, to read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
    end else if (adv) begin
      // NOTE: non-blocking assignments let every stage shift from its old
      // neighbour in the same edge regardless of statement order.
      stage[0] <= in_pix;
      for (int i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_pix = stage[PIPE_LAT-1];

  // True when the output stage holds the only pixel still in flight.
  always_comb begin
    // NOTE: default first so no path through the loop leaves it unassigned (no latch).
    upstream_empty = 1'b1;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      if (stage[i].valid) upstream_empty = 1'b0;
    end
  end

endmodule

// File: rtl/mode7_scan_ctrl.sv
// Mode 7 frame scan controller: raster walk, frame-stable transform config, pixel stream.
// Build macro ANGLE_AUTO_ROTATE_EN: pending angle steps by one at the end of each frame.
module mode7_scan_ctrl
  import mode7_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cfg_wr,
  input  logic [COORD_W-1:0] cfg_origin_x,
  input  logic [COORD_W-1:0] cfg_origin_y,
  input  logic [COORD_W-1:0] cfg_offset_x,
  input  logic [COORD_W-1:0] cfg_offset_y,
  input  logic [ANGLE_W-1:0] cfg_angle,
  output logic [COORD_W-1:0] xf_x,
  output logic [COORD_W-1:0] xf_y,
  output logic [COORD_W-1:0] xf_origin_x,
  output logic [COORD_W-1:0] xf_origin_y,
  output logic [COORD_W-1:0] xf_offset_x,
  output logic [COORD_W-1:0] xf_offset_y,
  output logic [ANGLE_W-1:0] xf_angle,
  input  logic [COLOR_W-1:0] xf_color,
  mode7_scan_ctrl_if.master  pix,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err
);

  localparam logic [COORD_W-1:0] H_MAX = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_MAX = COORD_W'(V_ACTIVE - 1);

  state_t             state;
  cfg_t               pend;
  cfg_t               act;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  logic adv;
  logic issue;
  logic last_xy;
  logic final_hs;
  logic upstream_empty;
  pix_t s0_pix;
  pix_t tail_pix;

  // The pipe only stalls when a valid pixel sits unaccepted at the output.
  assign adv     = !pix.pix_valid || pix.pix_ready;
  assign issue   = (state == ST_RUN) && adv;
  assign last_xy = (x == H_MAX) && (y == V_MAX);

  assign s0_pix = '{valid: issue,
                    color: xf_color,
                    sof:   (x == '0) && (y == '0),
                    eol:   (x == H_MAX)};

  assign final_hs = (state == ST_DRAIN) && tail_pix.valid && pix.pix_ready && upstream_empty;

  mode7_pix_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_pipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .adv            (adv),
    .in_pix         (s0_pix),
    .out_pix        (tail_pix),
    .upstream_empty (upstream_empty)
  );

  assign pix.pix_valid = tail_pix.valid;
  assign pix.pix_color = tail_pix.color;
  assign pix.pix_sof   = tail_pix.sof;
  assign pix.pix_eol   = tail_pix.eol;

  // Frame sequencing and raster counters. Counters freeze on the final
  // coordinate so xf_x/xf_y keep showing the last issued pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_LOAD;
        ST_LOAD: begin
          x     <= '0;
          y     <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (adv) begin
            if (last_xy) begin
              state <= ST_DRAIN;
            end else if (x == H_MAX) begin
              x <= '0;
              y <= y + COORD_W'(1);
            end else begin
              x <= x + COORD_W'(1);
            end
          end
        end
        ST_DRAIN: if (final_hs) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Pending shadow takes CPU writes at any time; active copy changes only in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      act     <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_wr) begin
        pend.origin_x <= cfg_origin_x;
        pend.origin_y <= cfg_origin_y;
        pend.offset_x <= cfg_offset_x;
        pend.offset_y <= cfg_offset_y;
        if (cfg_angle > ANGLE_MAX) begin
          cfg_err <= 1'b1;
        end else begin
          pend.angle <= cfg_angle;
          cfg_err    <= 1'b0;
        end
      end
`ifdef ANGLE_AUTO_ROTATE_EN
      else if (state == ST_DONE) begin
        pend.angle <= angle_next(pend.angle);
      end
`endif
      if (state == ST_LOAD) act <= pend;
    end
  end

  assign xf_x        = x;
  assign xf_y        = y;
  assign xf_origin_x = act.origin_x;
  assign xf_origin_y = act.origin_y;
  assign xf_offset_x = act.offset_x;
  assign xf_offset_y = act.offset_y;
  assign xf_angle    = act.angle;

  assign busy       = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_DRAIN);
  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_mode7_scan_ctrl.sv
// Directed bench for mode7_scan_ctrl on a 4x2 raster with a colour = x + 4*y transform stub.
module tb_mode7_scan_ctrl;

`ifdef ANGLE_AUTO_ROTATE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cfg_wr;
  logic [15:0] cfg_origin_x, cfg_origin_y, cfg_offset_x, cfg_offset_y;
  logic [9:0]  cfg_angle;
  logic [15:0] xf_x, xf_y, xf_origin_x, xf_origin_y, xf_offset_x, xf_offset_y;
  logic [9:0]  xf_angle;
  logic [7:0]  xf_color;
  logic        busy, frame_done, cfg_err;

  int errors = 0;
  int checks = 0;

  mode7_scan_ctrl_if pix_if ();

  mode7_scan_ctrl #(
    .H_ACTIVE (4),
    .V_ACTIVE (2),
    .PIPE_LAT (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_wr       (cfg_wr),
    .cfg_origin_x (cfg_origin_x),
    .cfg_origin_y (cfg_origin_y),
    .cfg_offset_x (cfg_offset_x),
    .cfg_offset_y (cfg_offset_y),
    .cfg_angle    (cfg_angle),
    .xf_x         (xf_x),
    .xf_y         (xf_y),
    .xf_origin_x  (xf_origin_x),
    .xf_origin_y  (xf_origin_y),
    .xf_offset_x  (xf_offset_x),
    .xf_offset_y  (xf_offset_y),
    .xf_angle     (xf_angle),
    .xf_color     (xf_color),
    .pix          (pix_if),
    .busy         (busy),
    .frame_done   (frame_done),
    .cfg_err      (cfg_err)
  );

  // Transform stub: colour is the raster index on a 4-wide line.
  assign xf_color = xf_x[7:0] + {xf_y[5:0], 2'b00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [9:0] angle, input logic [15:0] origin);
    @(negedge clk);
    cfg_wr       = 1'b1;
    cfg_angle    = angle;
    cfg_origin_x = origin;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // One frame: start pulse, then per-cycle handshake scoring at the falling edge.
  task automatic run_frame(input bit stall, input bit mid_wr,
                           input logic [9:0] exp_angle, input logic [15:0] exp_origin);
    int hs = 0;
    int fd_cyc = -1;
    int last_hs = -1;
    int unstable = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_color = '0;
    logic prev_sof = 1'b0;
    logic prev_eol = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && fd_cyc < 0; c++) begin
      pix_if.pix_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (mid_wr && c == 3) begin
        cfg_wr = 1'b1; cfg_angle = 10'd90; cfg_origin_x = 16'h1234;
      end
      if (mid_wr && c == 4) cfg_wr = 1'b0;
      if (c == 6) begin
        check("frame_angle", xf_angle, exp_angle);
        check("frame_origin_x", xf_origin_x, exp_origin);
      end
      if (prev_stall && (pix_if.pix_color !== prev_color || pix_if.pix_sof !== prev_sof ||
                         pix_if.pix_eol !== prev_eol))
        unstable++;
      if (pix_if.pix_valid && pix_if.pix_ready) begin
        check("pix_color", pix_if.pix_color, hs);
        check("pix_sof", pix_if.pix_sof, (hs == 0));
        check("pix_eol", pix_if.pix_eol, (hs % 4 == 3));
        hs++;
        last_hs = c;
      end
      prev_stall = pix_if.pix_valid && !pix_if.pix_ready;
      prev_color = pix_if.pix_color;
      prev_sof   = pix_if.pix_sof;
      prev_eol   = pix_if.pix_eol;
      if (frame_done) fd_cyc = c;
      @(negedge clk);
    end
    pix_if.pix_ready = 1'b1;
    check("frame_done_seen", (fd_cyc >= 0), 1);
    check("handshakes", hs, 8);
    check("frame_done_timing", fd_cyc, last_hs + 1);
    check("stall_stable", unstable, 0);
    check("frame_done_pulse", frame_done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_wr = 1'b0;
    cfg_origin_x = '0; cfg_origin_y = '0; cfg_offset_x = '0; cfg_offset_y = '0;
    cfg_angle = '0;
    pix_if.pix_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_pix_valid", pix_if.pix_valid, 0);
    check("rst_pix_color", pix_if.pix_color, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_xf_angle", xf_angle, 0);
    check("rst_xf_x", xf_x, 0);
    rst_n = 1'b1;

    // Back-pressure-free frame, then stalled frame with a mid-frame config write.
    run_frame(1'b0, 1'b0, 10'd0, 16'h0000);
    run_frame(1'b1, 1'b1, AUTO ? 10'd1 : 10'd0, 16'h0000);
    run_frame(1'b0, 1'b0, AUTO ? 10'd91 : 10'd90, 16'h1234);

    // Illegal angle keeps the pending angle, other fields still land.
    cfg_write(10'd400, 16'h5678);
    check("cfg_err_set", cfg_err, 1);
    run_frame(1'b0, 1'b0, AUTO ? 10'd92 : 10'd90, 16'h5678);
    cfg_write(10'd10, 16'h5678);
    check("cfg_err_clear", cfg_err, 0);
    run_frame(1'b1, 1'b0, 10'd10, 16'h5678);

    // Angle wrap at 359 across consecutive frames.
    cfg_write(10'd359, 16'h5678);
    run_frame(1'b0, 1'b0, 10'd359, 16'h5678);
    run_frame(1'b0, 1'b0, AUTO ? 10'd0 : 10'd359, 16'h5678);
    run_frame(1'b0, 1'b0, AUTO ? 10'd1 : 10'd359, 16'h5678);

    // Abort after three accepted pixels.
    begin
      int hs = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 50 && hs < 3; c++) begin
        if (pix_if.pix_valid && pix_if.pix_ready) hs++;
        @(negedge clk);
      end
      check("abort_reached", hs, 3);
      rst_n = 1'b0;
      #1;
      check("abort_pix_valid", pix_if.pix_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_angle", xf_angle, 0);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        check("abort_frame_done", frame_done, 0);
      end
      rst_n = 1'b1;
    end
    run_frame(1'b0, 1'b0, 10'd0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode7_scan_ctrl.md
Name: mode7_scan_ctrl

Overview:
- Frame scan controller for the Mode 7 affine-transform datapath: walks every (x,y) of the active raster, drives coordinates plus a frame-stable configuration (origins, offsets, angle) into the combinational transform/texel-lookup unit, and returns the resulting colour as a valid/ready pixel stream.
- Sits between the CPU/register block (config writes, start) and the video output FIFO; the only block that changes transform inputs.

Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- PIPE_LAT, 2, internal register stages between colour sample and pix_color (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin one frame
- cfg_wr  in  1  write all cfg_* into pending shadow registers
- cfg_origin_x, cfg_origin_y  in  16 each  rotation origin
- cfg_offset_x, cfg_offset_y  in  16 each  scroll offset
- cfg_angle  in  10  angle index, legal 0..359
- xf_x, xf_y  out  16 each  current pixel coordinate to transform unit
- xf_origin_x, xf_origin_y, xf_offset_x, xf_offset_y  out  16 each  active config
- xf_angle  out  10  active angle
- xf_color  in  8  colour returned combinationally by transform unit
- pix_valid  out  1  pixel stream valid
- pix_ready  in  1  downstream accept
- pix_color  out  8  pixel colour
- pix_sof, pix_eol  out  1 each  first pixel of frame / last pixel of line, aligned with pix_color
- busy  out  1  high in LOAD/RUN/DRAIN
- frame_done  out  1  one-cycle pulse when last pixel accepted
- cfg_err  out  1  sticky: cfg_wr carried cfg_angle>359; cleared by next legal cfg_wr

Behaviour:
- Reset: all outputs 0; state IDLE; pending and active config 0; counters 0.
- FSM: IDLE -start-> LOAD (1 cycle: pending->active copy, x=y=0) -> RUN -> DRAIN -> DONE (1 cycle, frame_done=1) -> IDLE.
- start outside IDLE ignored. cfg_wr legal in any state; affects pending only, so the active config is constant for a whole frame. cfg_wr with cfg_angle>359: all other fields written, pending angle kept, cfg_err set.
- adv = !pix_valid || pix_ready; every pipeline stage and the x/y counters move only when adv=1 (whole-pipe stall, no bubbles inserted, no pixel lost or duplicated).
- RUN, adv=1: sample xf_color with current xf_x/xf_y into stage 0 with sof=(x==0&&y==0), eol=(x==H_ACTIVE-1); x increments, wraps to 0 at H_ACTIVE-1 with y++; after issuing (H_ACTIVE-1,V_ACTIVE-1) go DRAIN.
- Latency: coordinate presented in cycle N appears on pix_color in cycle N+PIPE_LAT with no stalls.
- DRAIN: no new samples; exit to DONE when final pixel handshake (pix_valid&&pix_ready) occurs.
- xf_x/xf_y hold the last issued value in DRAIN/IDLE; xf_* config outputs always show active registers.
- Exactly H_ACTIVE*V_ACTIVE handshakes per frame; pix_color/sof/eol stable while pix_valid&&!pix_ready.
- Counters 16-bit; no wrap beyond V_ACTIVE.
- rst_n low mid-frame: immediate abort, pipeline valids cleared, no frame_done.

Optional Feature:
- ANGLE_AUTO_ROTATE_EN defined: in DONE the pending angle increments by 1, wrapping 359->0, unless cfg_wr is asserted that cycle (cfg_wr wins). Undefined: angle changes only via cfg_wr.

Decomposition:
- Shared package mode7_pkg: COORD_W=16, ANGLE_W=10, COLOR_W=8, ANGLE_MAX=359, default raster constants, FSM state enum.
- One sub-module: mode7_pix_pipe (PIPE_LAT-deep stalled shift pipeline of {valid,color,sof,eol} with adv enable); FSM, counters, config shadows stay in top.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2, PIPE_LAT=2, xf_color=xf_x+4*xf_y, pix_ready=1, start -> colours 0..7 in order, sof on 0, eol on 3 and 7, frame_done 1 cycle after colour 7 accepted, busy low afterward.
- Same, pix_ready toggling 1,0,0,1 repeating -> identical sequence 0..7, outputs stable during stalls, exactly 8 handshakes.
- cfg_wr angle=90 mid-frame with active angle=0 -> xf_angle stays 0 until next LOAD, then 90.
- cfg_wr angle=400 -> cfg_err=1, pending angle unchanged; then cfg_wr angle=10 -> cfg_err=0.
- rst_n low after 3 pixels -> pix_valid=0, state IDLE, no frame_done; start restarts at colour 0 with sof.
- ANGLE_AUTO_ROTATE_EN, angle=359, two frames -> second frame xf_angle=0, third 1.
